// File: rtl/engagement_sequencer.sv
// Engagement sequencer: track -> wait for range -> evaluate -> fire salvo -> done pulse with result.
// Optional re-track on timeout/out-of-range outcomes when ENGAGE_RETRACK_EN is defined.
module engagement_sequencer #(
    parameter logic [13:0] MIN_RANGE     = 14'd500,
    parameter logic [13:0] MAX_RANGE     = 14'd12000,
    parameter int          TRACK_TIMEOUT = 200,
    parameter int          SALVO_SIZE    = 2,
    parameter int          FIRE_PULSE    = 2,
    parameter int          FIRE_GAP      = 2,
    parameter int          RETRY_MAX     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        engage_req,
    input  logic        abort,
    input  logic        range_valid,
    input  logic [13:0] distance_to_target,
    input  logic [3:0]  remaining_missiles,
    output logic        track_target_command,
    output logic        fire_command,
    output logic        busy,
    output logic        engage_done,
    output logic [2:0]  engage_result,
    output logic [3:0]  shots_fired,
    output logic [2:0]  seq_state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_TRACK = 3'd1, S_WAIT_RANGE = 3'd2, S_EVAL = 3'd3,
        S_FIRE = 3'd4, S_GAP = 3'd5, S_DONE = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        R_FIRED = 3'd0, R_OUT_OF_RANGE = 3'd1, R_TIMEOUT = 3'd2, R_NO_AMMO = 3'd3, R_ABORTED = 3'd4
    } result_t;

    localparam int TW = $clog2(TRACK_TIMEOUT + 1);
    localparam int PMAX = (FIRE_PULSE > FIRE_GAP) ? FIRE_PULSE : FIRE_GAP;
    localparam int PW = $clog2(PMAX + 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TRACK_TIMEOUT - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(FIRE_PULSE - 1);
    localparam logic [PW-1:0] GAP_LAST   = PW'(FIRE_GAP - 1);
    localparam logic [3:0]    SALVO      = 4'(SALVO_SIZE);

    state_t         state;
    result_t        pend_result;
    logic [13:0]    dist_q;
    logic [TW-1:0]  to_cnt;
    logic [PW-1:0]  ph_cnt;
    logic           in_range;
    logic           fail_now;
    result_t        fail_code;

`ifdef ENGAGE_RETRACK_EN
    localparam int RW = $clog2(RETRY_MAX + 2);
    logic [RW-1:0] retry_cnt;
`endif

    assign seq_state = state;
    assign in_range  = (dist_q >= MIN_RANGE) && (dist_q <= MAX_RANGE);

    // Timeout and out-of-range share one exit path so the retry decision lives in one place.
    always_comb begin
        fail_now  = 1'b0;
        fail_code = R_TIMEOUT;
        if (state == S_WAIT_RANGE && !range_valid && to_cnt == TO_LAST) begin
            fail_now = 1'b1;
        end else if (state == S_EVAL && !in_range) begin
            fail_now  = 1'b1;
            fail_code = R_OUT_OF_RANGE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= S_IDLE;
            pend_result          <= R_FIRED;
            dist_q               <= '0;
            to_cnt               <= '0;
            ph_cnt               <= '0;
            track_target_command <= 1'b0;
            fire_command         <= 1'b0;
            busy                 <= 1'b0;
            engage_done          <= 1'b0;
            engage_result        <= '0;
            shots_fired          <= '0;
`ifdef ENGAGE_RETRACK_EN
            retry_cnt            <= '0;
`endif
        end else begin
            track_target_command <= 1'b0;
            engage_done          <= 1'b0;
            if (abort && state != S_IDLE && state != S_DONE) begin
                state        <= S_DONE;
                pend_result  <= R_ABORTED;
                fire_command <= 1'b0;
            end else if (fail_now) begin
`ifdef ENGAGE_RETRACK_EN
                if (retry_cnt < RW'(RETRY_MAX)) begin
                    state                <= S_TRACK;
                    track_target_command <= 1'b1;
                    retry_cnt            <= retry_cnt + RW'(1);
                end else
`endif
                begin
                    state       <= S_DONE;
                    pend_result <= fail_code;
                end
            end else begin
                case (state)
                    S_IDLE: if (engage_req && !abort) begin
                        busy        <= 1'b1;
                        shots_fired <= '0;
`ifdef ENGAGE_RETRACK_EN
                        retry_cnt   <= '0;
`endif
                        if (remaining_missiles == 4'd0) begin
                            state       <= S_DONE;
                            pend_result <= R_NO_AMMO;
                        end else begin
                            state                <= S_TRACK;
                            track_target_command <= 1'b1;
                        end
                    end
                    S_TRACK: begin
                        state  <= S_WAIT_RANGE;
                        to_cnt <= '0;
                    end
                    S_WAIT_RANGE: begin
                        if (range_valid) begin
                            dist_q <= distance_to_target;
                            state  <= S_EVAL;
                        end else begin
                            to_cnt <= to_cnt + TW'(1);
                        end
                    end
                    S_EVAL: begin
                        state        <= S_FIRE;
                        fire_command <= 1'b1;
                        shots_fired  <= shots_fired + 4'd1;
                        ph_cnt       <= '0;
                    end
                    S_FIRE: begin
                        if (ph_cnt == PULSE_LAST) begin
                            fire_command <= 1'b0;
                            ph_cnt       <= '0;
                            if (shots_fired == SALVO || remaining_missiles == 4'd0) begin
                                state       <= S_DONE;
                                pend_result <= R_FIRED;
                            end else begin
                                state <= S_GAP;
                            end
                        end else begin
                            ph_cnt <= ph_cnt + PW'(1);
                        end
                    end
                    S_GAP: begin
                        if (ph_cnt == GAP_LAST) begin
                            ph_cnt <= '0;
                            if (remaining_missiles == 4'd0) begin
                                state       <= S_DONE;
                                pend_result <= R_FIRED;
                            end else begin
                                state        <= S_FIRE;
                                fire_command <= 1'b1;
                                shots_fired  <= shots_fired + 4'd1;
                            end
                        end else begin
                            ph_cnt <= ph_cnt + PW'(1);
                        end
                    end
                    S_DONE: begin
                        engage_done   <= 1'b1;
                        engage_result <= pend_result;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end
                    default: begin
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        fire_command <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
